// File: rtl/sideband_debounce.sv
// Per-bit debounce for synchronized QSFP sideband levels: each bit must hold a new
// level for DEBOUNCE_CYCLES sample ticks before it is committed to dout.
module sideband_debounce #(
  parameter int   WIDTH           = 4,
  parameter int   CNT_W           = 16,
  parameter int   DEBOUNCE_CYCLES = 1000,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  input  logic             sample_en,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] sticky_chg,
  input  logic [WIDTH-1:0] clr_chg,
  output logic [WIDTH-1:0] busy
);

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state [WIDTH];
  logic [CNT_W-1:0] cnt   [WIDTH];

  // Glitch check outranks sample_en, so a level that bounces back never commits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= STABLE;
        cnt[i]   <= '0;
      end
      dout       <= {WIDTH{RESET_VALUE}};
      rise_pulse <= '0;
      fall_pulse <= '0;
      sticky_chg <= '0;
      busy       <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        rise_pulse[i] <= 1'b0;
        fall_pulse[i] <= 1'b0;
        if (clr_chg[i]) begin
          sticky_chg[i] <= 1'b0;
        end
        case (state[i])
          STABLE: begin
            if (din[i] != dout[i]) begin
              state[i] <= QUALIFY;
              cnt[i]   <= '0;
              busy[i]  <= 1'b1;
            end
          end
          QUALIFY: begin
            if (din[i] == dout[i]) begin
              state[i] <= STABLE;
              cnt[i]   <= '0;
              busy[i]  <= 1'b0;
            end else if (sample_en && (cnt[i] == CNT_LAST)) begin
              dout[i]       <= din[i];
              rise_pulse[i] <= din[i];
              fall_pulse[i] <= ~din[i];
              sticky_chg[i] <= 1'b1;
              state[i]      <= STABLE;
              cnt[i]        <= '0;
              busy[i]       <= 1'b0;
            end else if (sample_en) begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          default: begin
            state[i] <= STABLE;
            cnt[i]   <= '0;
            busy[i]  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sideband_debounce.sv
// Directed testbench for sideband_debounce with DEBOUNCE_CYCLES = 4.
module tb_sideband_debounce;

  localparam int WIDTH = 4;

  logic             clk;
  logic             resetn;
  logic [WIDTH-1:0] din;
  logic             sample_en;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic [WIDTH-1:0] sticky_chg;
  logic [WIDTH-1:0] clr_chg;
  logic [WIDTH-1:0] busy;

  int checks;
  int errors;

  sideband_debounce #(
    .WIDTH(WIDTH),
    .CNT_W(16),
    .DEBOUNCE_CYCLES(4),
    .RESET_VALUE(1'b0)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .din(din),
    .sample_en(sample_en),
    .dout(dout),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .sticky_chg(sticky_chg),
    .clr_chg(clr_chg),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    tick();
    checks++;
    if (dout !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_dout: got %b expected %b", dout, 4'b0000);
    end
    checks++;
    if ({rise_pulse, fall_pulse, sticky_chg, busy} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %h expected %h",
               {rise_pulse, fall_pulse, sticky_chg, busy}, 16'h0000);
    end
    resetn = 1'b1;
  endtask

  task automatic test_clean_rise();
    din[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({busy[0], dout[0], rise_pulse[0]} !== 3'b100) begin
        errors++;
        $display("[TB] FAIL rise_qualify k=%0d: got busy/dout/rise %b expected %b",
                 k, {busy[0], dout[0], rise_pulse[0]}, 3'b100);
      end
    end
    tick();
    checks++;
    if ({busy[0], dout[0], rise_pulse[0], fall_pulse[0], sticky_chg[0]} !== 5'b01101) begin
      errors++;
      $display("[TB] FAIL rise_commit: got busy/dout/rise/fall/sticky %b expected %b",
               {busy[0], dout[0], rise_pulse[0], fall_pulse[0], sticky_chg[0]}, 5'b01101);
    end
    tick();
    checks++;
    if ({dout[0], rise_pulse[0]} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL rise_after: got dout/rise %b expected %b",
               {dout[0], rise_pulse[0]}, 2'b10);
    end
  endtask

  task automatic test_glitch();
    din[1] = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (busy[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL glitch_busy: got %b expected %b", busy[1], 1'b1);
    end
    din[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({busy[1], dout[1], rise_pulse[1], fall_pulse[1], sticky_chg[1]} !== 5'b00000) begin
        errors++;
        $display("[TB] FAIL glitch_reject k=%0d: got busy/dout/rise/fall/sticky %b expected %b",
                 k, {busy[1], dout[1], rise_pulse[1], fall_pulse[1], sticky_chg[1]}, 5'b00000);
      end
    end
  endtask

  task automatic test_sample_gating();
    din[2] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if ({dout[2], rise_pulse[2]} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL gate_setup: got dout/rise %b expected %b",
               {dout[2], rise_pulse[2]}, 2'b11);
    end
    clr_chg = 4'b0100;
    tick();
    clr_chg = 4'b0000;
    checks++;
    if (sticky_chg[2] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gate_clr: got %b expected %b", sticky_chg[2], 1'b0);
    end
    din[2] = 1'b0;
    // Ticks land on edges 3, 6, 9 and 12 after entering QUALIFY at edge 0.
    for (int n = 0; n <= 13; n++) begin
      sample_en = (n != 0) && (n % 3 == 0);
      tick();
      checks++;
      if ({dout[2], fall_pulse[2], rise_pulse[2], busy[2]} !==
          {(n < 12), (n == 12), 1'b0, (n < 12)}) begin
        errors++;
        $display("[TB] FAIL gate_fall n=%0d: got dout/fall/rise/busy %b expected %b", n,
                 {dout[2], fall_pulse[2], rise_pulse[2], busy[2]},
                 {(n < 12), (n == 12), 1'b0, (n < 12)});
      end
    end
    sample_en = 1'b1;
  endtask

  task automatic test_sticky_collision();
    din[0] = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    clr_chg = 4'b0001;
    tick();
    checks++;
    if ({dout[0], fall_pulse[0], sticky_chg[0]} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL sticky_collide: got dout/fall/sticky %b expected %b",
               {dout[0], fall_pulse[0], sticky_chg[0]}, 3'b011);
    end
    tick();
    clr_chg = 4'b0000;
    checks++;
    if ({fall_pulse[0], sticky_chg[0]} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL sticky_clear: got fall/sticky %b expected %b",
               {fall_pulse[0], sticky_chg[0]}, 2'b00);
    end
  endtask

  task automatic test_reset_mid_qualify();
    din[1] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (dout !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL rstq_setup: got %b expected %b", dout, 4'b0010);
    end
    din[3] = 1'b1;
    tick();
    tick();
    tick();
    resetn = 1'b0;
    #1;
    checks++;
    if ({dout, busy, sticky_chg, rise_pulse | fall_pulse} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL rstq_abort: got dout/busy/sticky/pulse %h expected %h",
               {dout, busy, sticky_chg, rise_pulse | fall_pulse}, 16'h0000);
    end
    tick();
    tick();
    checks++;
    if ({dout, busy} !== 8'h00) begin
      errors++;
      $display("[TB] FAIL rstq_hold: got dout/busy %h expected %h", {dout, busy}, 8'h00);
    end
    resetn = 1'b1;
    for (int n = 0; n <= 5; n++) begin
      tick();
      checks++;
      if ({dout, rise_pulse, busy} !==
          {((n >= 4) ? 4'b1010 : 4'b0000), ((n == 4) ? 4'b1010 : 4'b0000),
           ((n < 4) ? 4'b1010 : 4'b0000)}) begin
        errors++;
        $display("[TB] FAIL rstq_requal n=%0d: got dout/rise/busy %h expected %h", n,
                 {dout, rise_pulse, busy},
                 {((n >= 4) ? 4'b1010 : 4'b0000), ((n == 4) ? 4'b1010 : 4'b0000),
                  ((n < 4) ? 4'b1010 : 4'b0000)});
      end
    end
  endtask

  task automatic test_multi_bit();
    din[0] = 1'b1;
    for (int n = 0; n <= 7; n++) begin
      if (n == 2) din[3] = 1'b0;
      tick();
      checks++;
      if ({rise_pulse[0], fall_pulse[3], dout[0], dout[3], fall_pulse[0], rise_pulse[3]} !==
          {(n == 4), (n == 6), (n >= 4), (n < 6), 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL multi n=%0d: got rise0/fall3/dout0/dout3/fall0/rise3 %b expected %b", n,
                 {rise_pulse[0], fall_pulse[3], dout[0], dout[3], fall_pulse[0], rise_pulse[3]},
                 {(n == 4), (n == 6), (n >= 4), (n < 6), 1'b0, 1'b0});
      end
    end
    checks++;
    if (sticky_chg !== 4'b1011) begin
      errors++;
      $display("[TB] FAIL multi_sticky: got %b expected %b", sticky_chg, 4'b1011);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    resetn    = 1'b0;
    din       = '0;
    sample_en = 1'b1;
    clr_chg   = '0;
    test_reset();
    test_clean_rise();
    test_glitch();
    test_sample_gating();
    test_sticky_collision();
    test_reset_mid_qualify();
    test_multi_bit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
